// File: rtl/tt_um_k_ziegler_27.sv
// 8-bit accumulator ALU as a TinyTapeout tile: operand on ui_in, opcode/strobe on uio_in,
// accumulator on uo_out and Z/C/N/V flags on the upper bidirectional pins.
module tt_um_k_ziegler_27 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } opcode_t;

  logic [7:0] acc;
  logic       flag_z, flag_c, flag_n, flag_v;

  opcode_t    opcode;
  logic       exec;
  logic [7:0] res;
  logic       res_c, res_v;
  logic [8:0] wide;
  logic       unused_bits;

  assign opcode      = opcode_t'(uio_in[2:0]);
  assign exec        = ena & uio_in[3];
  assign unused_bits = ^uio_in[7:4];

  // The 9-bit add/subtract carries the carry-out or borrow in bit 8.
  always_comb begin
    res   = acc;
    res_c = 1'b0;
    res_v = 1'b0;
    wide  = 9'd0;
    case (opcode)
      OP_LOAD: res = ui_in;
      OP_ADD: begin
        wide  = {1'b0, acc} + {1'b0, ui_in};
        res   = wide[7:0];
        res_c = wide[8];
        res_v = (acc[7] == ui_in[7]) && (wide[7] != acc[7]);
      end
      OP_SUB: begin
        wide  = {1'b0, acc} - {1'b0, ui_in};
        res   = wide[7:0];
        res_c = wide[8];
        res_v = (acc[7] != ui_in[7]) && (wide[7] != acc[7]);
      end
      OP_AND: res = acc & ui_in;
      OP_OR:  res = acc | ui_in;
      OP_XOR: res = acc ^ ui_in;
      OP_SHL: begin
        res   = {acc[6:0], 1'b0};
        res_c = acc[7];
      end
      OP_SHR: begin
        res   = {1'b0, acc[7:1]};
        res_c = acc[0];
      end
      default: res = acc;
    endcase
  end

  // rst_n is an active-high synchronous reset despite its harness pin name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc    <= 8'h00;
      flag_z <= 1'b1;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (exec) begin
      acc    <= res;
      flag_z <= (res == 8'h00);
      flag_c <= res_c;
      flag_n <= res[7];
      flag_v <= res_v;
    end
  end

  assign uo_out  = acc;
  assign uio_out = {flag_v, flag_n, flag_c, flag_z, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_k_ziegler_27.sv
// Bench for tt_um_k_ziegler_27: directed vector table, then randomized ops against an
// arithmetic reference model, all routed through an expected-value queue.
module tb_tt_um_k_ziegler_27;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_k_ziegler_27 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic       stb;
    logic [2:0] op;
    logic [7:0] b;
    logic [7:0] exp_acc;
    logic [7:0] exp_flags;
  } vec_t;

  typedef struct {
    logic [7:0] acc;
    logic [7:0] flags;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors;
  int   checks;

  logic [7:0] m_acc;
  logic       m_z, m_c, m_n, m_v;

  function automatic vec_t mk(input logic r, input logic e, input logic s, input logic [2:0] op,
                              input logic [7:0] b, input logic [7:0] ea, input logic [7:0] ef);
    vec_t v;
    v.rst = r; v.en = e; v.stb = s; v.op = op; v.b = b;
    v.exp_acc = ea; v.exp_flags = ef;
    return v;
  endfunction

  // Reference model written with integer arithmetic rather than bit-level formulas.
  task automatic model_step(input logic r, input logic e, input logic s,
                            input logic [2:0] op, input logic [7:0] b);
    int u, sg;
    logic [7:0] res;
    logic c, v;
    if (r) begin
      m_acc = 8'h00; m_z = 1'b1; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
    end else if (e && s) begin
      c = 1'b0; v = 1'b0; res = m_acc;
      case (op)
        3'd0: res = b;
        3'd1: begin
          u  = int'(m_acc) + int'(b);
          sg = int'($signed(m_acc)) + int'($signed(b));
          res = 8'(u); c = (u > 255); v = (sg > 127) || (sg < -128);
        end
        3'd2: begin
          u  = int'(m_acc) - int'(b);
          sg = int'($signed(m_acc)) - int'($signed(b));
          res = 8'(u); c = (u < 0); v = (sg > 127) || (sg < -128);
        end
        3'd3: res = m_acc & b;
        3'd4: res = m_acc | b;
        3'd5: res = m_acc ^ b;
        3'd6: begin res = 8'((int'(m_acc) * 2) % 256); c = (m_acc >= 8'h80); end
        default: begin res = 8'(int'(m_acc) / 2); c = (int'(m_acc) % 2 == 1); end
      endcase
      m_acc = res; m_c = c; m_v = v; m_z = (res == 8'h00); m_n = (res >= 8'h80);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    exp_t x;
    @(negedge clk);
    rst_n  = v.rst;
    ena    = v.en;
    ui_in  = v.b;
    uio_in = {4'b1010, v.stb, v.op};
    x.acc = v.exp_acc; x.flags = v.exp_flags; x.tag = tag;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t x;
    if (exp_q.size() == 0) begin
      errors++; checks++;
      $display("[TB] FAIL scoreboard: queue empty, got nothing, required one entry");
      return;
    end
    x = exp_q.pop_front();
    checks++;
    if (uo_out !== x.acc) begin
      errors++;
      $display("[TB] FAIL %s acc: got %h, required %h", x.tag, uo_out, x.acc);
    end
    checks++;
    if (uio_out !== x.flags) begin
      errors++;
      $display("[TB] FAIL %s flags: got %h, required %h", x.tag, uio_out, x.flags);
    end
    checks++;
    if (uio_oe !== 8'hF0) begin
      errors++;
      $display("[TB] FAIL %s oe: got %h, required f0", x.tag, uio_oe);
    end
  endtask

  initial begin
    vec_t v;
    errors = 0; checks = 0;
    rst_n = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

    // Directed table: {rst, ena, strobe, op, B, expected acc, expected uio_out}
    vecs.push_back(mk(1, 0, 0, 3'd0, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(1, 0, 0, 3'd0, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(0, 1, 0, 3'd0, 8'h00, 8'h00, 8'h10));
    vecs.push_back(mk(0, 1, 1, 3'd0, 8'h7F, 8'h7F, 8'h00));
    vecs.push_back(mk(0, 1, 1, 3'd1, 8'h01, 8'h80, 8'hC0));
    vecs.push_back(mk(0, 1, 1, 3'd1, 8'h80, 8'h00, 8'hB0));
    vecs.push_back(mk(0, 1, 1, 3'd0, 8'h05, 8'h05, 8'h00));
    vecs.push_back(mk(0, 1, 1, 3'd2, 8'h07, 8'hFE, 8'h60));
    vecs.push_back(mk(0, 1, 1, 3'd2, 8'hFE, 8'h00, 8'h10));
    vecs.push_back(mk(0, 1, 1, 3'd0, 8'h80, 8'h80, 8'h40));
    vecs.push_back(mk(0, 1, 1, 3'd2, 8'h01, 8'h7F, 8'h80));
    vecs.push_back(mk(0, 1, 1, 3'd0, 8'hA5, 8'hA5, 8'h40));
    vecs.push_back(mk(0, 1, 1, 3'd3, 8'h0F, 8'h05, 8'h00));
    vecs.push_back(mk(0, 1, 1, 3'd4, 8'hF0, 8'hF5, 8'h40));
    vecs.push_back(mk(0, 1, 1, 3'd5, 8'hFF, 8'h0A, 8'h00));
    vecs.push_back(mk(0, 1, 1, 3'd6, 8'h33, 8'h14, 8'h00));
    vecs.push_back(mk(0, 1, 1, 3'd0, 8'h81, 8'h81, 8'h40));
    vecs.push_back(mk(0, 1, 1, 3'd7, 8'h55, 8'h40, 8'h20));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 3'd1, 8'h11, 8'h40, 8'h20));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0, 1, 0, 3'd1, 8'h11, 8'h40, 8'h20));
    vecs.push_back(mk(1, 1, 1, 3'd0, 8'hFF, 8'h00, 8'h10));
    vecs.push_back(mk(0, 1, 0, 3'd0, 8'hFF, 8'h00, 8'h10));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput();
    end

    // Randomized phase: expectations come from the reference model.
    model_step(1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    v = mk(1, 0, 0, 3'd0, 8'h00, m_acc, {m_v, m_n, m_c, m_z, 4'b0000});
    applyStimulus(v, "rnd_reset");
    checkOutput();
    for (int i = 0; i < 60; i++) begin
      v.rst = ($urandom_range(0, 19) == 0);
      v.en  = ($urandom_range(0, 7) != 0);
      v.stb = ($urandom_range(0, 5) != 0);
      v.op  = 3'($urandom_range(0, 7));
      v.b   = 8'($urandom_range(0, 255));
      model_step(v.rst, v.en, v.stb, v.op, v.b);
      v.exp_acc   = m_acc;
      v.exp_flags = {m_v, m_n, m_c, m_z, 4'b0000};
      applyStimulus(v, $sformatf("rnd%0d_op%0d", i, v.op));
      checkOutput();
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_k_ziegler_27.md
Name: tt_um_k_ziegler_27

Overview:
8-bit accumulator ALU packaged as a TinyTapeout user tile.
- Operand enters on ui_in; opcode and execute strobe enter on the low bidirectional pins.
- The accumulator drives uo_out; status flags drive the upper bidirectional pins.
- Sits directly under the TinyTapeout harness, pin-compatible with the standard tile interface.

Parameters:
None. Datapath width is fixed at 8 bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset; synchronous and active-high (reset applied when rst_n=1 at a rising clk edge; the name is the harness pin name only)
ena  input  1  tile enable; when 0 all state holds
ui_in  input  8  operand B
uio_in  input  8  [2:0] opcode, [3] execute strobe, [7:4] ignored
uo_out  output  8  accumulator value (registered)
uio_out  output  8  [4]=Z, [5]=C, [6]=N, [7]=V; [3:0]=0
uio_oe  output  8  constant 8'hF0 (upper nibble outputs, lower nibble inputs)

Behaviour:
- Reset (rst_n=1 at a clk edge): acc=8'h00, Z=1, C=0, N=0, V=0. Reset has priority over ena and strobe. Reset mid-operation discards the pending op.
- Execute condition: at a rising edge with rst_n=0, ena=1 and uio_in[3]=1.
- Strobe is level-sensitive: one op executes on every qualifying edge.
- Otherwise acc and all flags hold.
- Latency: result and flags appear on uo_out/uio_out one cycle after the executing edge. No combinational path from inputs to outputs.
- Opcodes (A=acc, B=ui_in):
  - 000 LOAD: A=B; C=0, V=0
  - 001 ADD: A=A+B mod 256; C=carry out of bit 7; V=signed overflow (A7==B7 && R7!=A7)
  - 010 SUB: A=A-B mod 256; C=borrow (1 iff B>A unsigned); V=signed overflow (A7!=B7 && R7!=A7)
  - 011 AND: A=A&B; C=0, V=0
  - 100 OR: A=A|B; C=0, V=0
  - 101 XOR: A=A^B; C=0, V=0
  - 110 SHL: A={A[6:0],0}; C=old A[7]; V=0; B ignored
  - 111 SHR (logical): A={0,A[7:1]}; C=old A[0]; V=0; B ignored
- After every executed op: Z=(new A==0), N=new A[7].
- Wrap-around: ADD/SUB wrap modulo 256 with no saturation; flags report the wrap.
- ena=0 with strobe=1: no op, full hold.
- uio_oe is 8'hF0 at all times, including during reset.
- uio_out[3:0] is always 0.

Test Plan:
- Reset: rst_n=1 for 2 cycles, then rst_n=0 -> uo_out=00, uio_out=8'h10 (Z=1), uio_oe=F0.
- LOAD then ADD: LOAD 8'h7F, then ADD 8'h01 -> uo_out=80, N=1, V=1, C=0, Z=0 (uio_out=C0). Then ADD 8'h80 -> uo_out=00, C=1, V=1, Z=1 (uio_out=B0).
- SUB: LOAD 8'h05, SUB 8'h07 -> uo_out=FE, C=1 (borrow), N=1, V=0. Then SUB 8'hFE -> uo_out=00, Z=1, C=0.
- Logic and shifts:
  - LOAD A5, AND 0F -> 05.
  - OR F0 -> F5.
  - XOR FF -> 0A.
  - SHL -> 14, C=0.
  - LOAD 81, SHR -> 40, C=1.
- Hold: ena=0 with strobe=1 and opcode ADD for 5 cycles -> acc and flags unchanged. Strobe=0 with ena=1 -> unchanged.
- Reset priority: strobe=1 with LOAD FF issued on the same edge as rst_n=1 -> uo_out=00, Z=1 the next cycle.
